fifo_rx: RTL and testbench
==========================

FIFO_RX -- requirements
Module: fifo_rx

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set byte width in bits.
REQ-002 Parameter DEPTH, default 64 (power of two), SHALL set FIFO entries; PTR_WIDTH = clog2(DEPTH).
REQ-003 clk  in  1  system clock, 50 MHz.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 en_IQ  in  1  receive enable; high while a serial byte stream is present.
REQ-006 data_in  in  1  serial data bit, LSB first.
REQ-007 IQ_rate  in  1  2 MHz bit-rate level; rising edge marks the sample point.
REQ-008 psel, penable, pwrite  in  1 each  APB slave controls.
REQ-009 prdata  out  WIDTH  APB read data.
REQ-010 pready  out  1  APB ready, tied 1.
REQ-011 pslverr  out  1  APB error.
REQ-012 mem_state  out  1  0 = FIFO empty, 1 = at least one byte stored.
REQ-013 overflow  out  1  sticky: a received byte was dropped.

Function
REQ-014 The block SHALL register IQ_rate once and form strobe = IQ_rate & ~IQ_rate_q; no further synchronisation is applied.
REQ-015 The deserialiser FSM SHALL have states IDLE and SHIFT; IDLE->SHIFT when en_IQ=1; SHIFT->IDLE when en_IQ=0.
REQ-016 In SHIFT, each strobe SHALL write data_in into shift_reg[bit_cnt] and increment the 3-bit bit_cnt.
REQ-017 On the strobe where bit_cnt=7, the assembled byte (including this bit) SHALL be pushed in the next cycle, bit_cnt wraps to 0.
REQ-018 Leaving SHIFT with bit_cnt≠0 SHALL discard the partial byte; bit_cnt and shift_reg SHALL clear in IDLE.
REQ-019 Strobes in IDLE SHALL be ignored.
REQ-020 FIFO SHALL use (PTR_WIDTH+1)-bit wr_ptr/rd_ptr; empty = pointers equal; full = low bits equal, MSBs differ.
REQ-021 Push SHALL be accepted when !full, or when full and an APB pop occurs in the same cycle.
REQ-022 A rejected push SHALL drop the byte, leave pointers unchanged and set overflow to 1.
REQ-023 APB pop SHALL occur when psel & penable & ~pwrite & ~empty; rd_ptr increments on that clock edge.
REQ-024 prdata SHALL equal mem[rd_ptr] combinationally while ~empty and 0 while empty.
REQ-025 pslverr SHALL be 1 during an access phase (psel & penable) that reads while empty; 0 otherwise.
REQ-026 An APB write access phase SHALL clear overflow, store nothing, and return pslverr=0.
REQ-027 Simultaneous push and pop SHALL both complete; occupancy unchanged.
REQ-028 Pointers SHALL wrap modulo 2*DEPTH without error.
REQ-029 mem_state SHALL equal ~empty, combinational.

Reset
REQ-030 On a clk edge with reset_n=0: FSM=IDLE, bit_cnt=0, shift_reg=0, IQ_rate_q=0, wr_ptr=rd_ptr=0, overflow=0.
REQ-031 During and after reset: prdata=0, pslverr=0, mem_state=0, pready=1; storage array is not reset.
REQ-032 Reset mid-byte or mid-read SHALL discard all partial and stored data.

Structure
REQ-033 Package fifo_pkg SHALL hold the rx FSM enum (IDLE, SHIFT) and default WIDTH/DEPTH constants.
REQ-034 Storage, pointers and full/empty SHALL live in sub-module fifo_core (push/pop/din/dout/full/empty), instantiated once.

Verification
REQ-035 en_IQ=1, bits of 0xA5 LSB-first, one per IQ_rate rising edge -> mem_state=1; APB read returns 0xA5, pslverr=0, mem_state=0.
REQ-036 APB read with FIFO empty -> prdata=0x00, pslverr=1, rd_ptr unchanged.
REQ-037 Receive 65 bytes 0x00..0x40 with no reads -> overflow=1; 64 reads return 0x00..0x3F; 65th read pslverr=1.
REQ-038 en_IQ drops after 3 bits, then full byte 0x3C -> only 0x3C stored.
REQ-039 FIFO full, byte completes in same cycle as APB read -> both succeed, overflow stays 0, occupancy stays 64.
REQ-040 reset_n=0 for one clk after 5 stored bytes and 4 bits shifted -> mem_state=0, overflow=0, next read pslverr=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the serial receive FIFO.
// Holds the deserialiser state encoding.
package fifo_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 64;

  typedef enum logic {
    IDLE,
    SHIFT
  } rx_state_t;

endpackage

// File: rtl/fifo_rx_if.sv
// APB slave bundle for the receive FIFO.
// Master drives the controls; slave returns data.
interface fifo_rx_if #(
  parameter int WIDTH = 8
) ();

  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [WIDTH-1:0] prdata;
  logic             pready;
  logic             pslverr;

  modport master (
    output psel,
    output penable,
    output pwrite,
    input  prdata,
    input  pready,
    input  pslverr
  );

  modport slave (
    input  psel,
    input  penable,
    input  pwrite,
    output prdata,
    output pready,
    output pslverr
  );

endinterface

// File: rtl/fifo_core.sv
// Pointer-based storage with full/empty flags.
// A push into a full FIFO lands only if a pop frees a slot.
module fifo_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0])
              && (wr_ptr[PW] != rd_ptr[PW]);

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr[PW-1:0]];

  // Pointer update; wrap is the natural modulo-2*DEPTH rollover
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array is deliberately left unreset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/fifo_rx.sv
// Serial byte receiver feeding an APB-readable FIFO.
// Bits arrive LSB first on each IQ_rate rising edge.
module fifo_rx
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en_IQ,
  input  logic       data_in,
  input  logic       IQ_rate,
  output logic       mem_state,
  output logic       overflow,
  fifo_rx_if.slave   apb
);

  localparam int CW = $clog2(WIDTH);

  rx_state_t        state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic             IQ_rate_q;
  logic             strobe;
  logic             push;
  logic             pop;
  logic             rd_acc;
  logic             wr_acc;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] dout;

  assign strobe = IQ_rate & ~IQ_rate_q;
  assign rd_acc = apb.psel & apb.penable & ~apb.pwrite;
  assign wr_acc = apb.psel & apb.penable & apb.pwrite;
  assign pop    = rd_acc & ~empty;

  assign apb.prdata  = empty ? '0 : dout;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = rd_acc & empty;
  assign mem_state   = ~empty;

  // Rate edge detector: one stage, no synchroniser
  always_ff @(posedge clk) begin
    if (!reset_n) IQ_rate_q <= 1'b0;
    else          IQ_rate_q <= IQ_rate;
  end

  // Deserialiser; push fires the cycle after the last bit lands
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      push      <= 1'b0;
    end else begin
      push <= 1'b0;
      unique case (state)
        IDLE: begin
          bit_cnt   <= '0;
          shift_reg <= '0;
          if (en_IQ) state <= SHIFT;
        end
        SHIFT: begin
          if (!en_IQ) begin
            state <= IDLE;
          end else if (strobe) begin
            shift_reg[bit_cnt] <= data_in;
            bit_cnt            <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(WIDTH - 1)) push <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (!reset_n)                  overflow <= 1'b0;
    else if (push & full & ~pop)   overflow <= 1'b1;
    else if (wr_acc)               overflow <= 1'b0;
  end

  fifo_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (shift_reg),
    .dout    (dout),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_fifo_rx.sv
// Directed bench for fifo_rx: serial receive,
// APB drain, overflow, abort and reset cases.
module tb_fifo_rx;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en_IQ = 1'b0;
  logic data_in = 1'b0;
  logic IQ_rate = 1'b0;
  logic mem_state;
  logic overflow;

  int total = 0;
  int bad = 0;

  fifo_rx_if #(.WIDTH(8)) apb ();

  fifo_rx dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en_IQ     (en_IQ),
    .data_in   (data_in),
    .IQ_rate   (IQ_rate),
    .mem_state (mem_state),
    .overflow  (overflow),
    .apb       (apb.slave)
  );

  always #10 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    data_in = b;
    IQ_rate = 1'b1;
    repeat (2) @(negedge clk);
    IQ_rate = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic apb_read(output logic [7:0] d,
                          output logic e);
    @(negedge clk);
    apb.psel = 1'b1;
    apb.pwrite = 1'b0;
    apb.penable = 1'b0;
    @(negedge clk);
    apb.penable = 1'b1;
    #1;
    d = apb.prdata;
    e = apb.pslverr;
    @(negedge clk);
    apb.psel = 1'b0;
    apb.penable = 1'b0;
  endtask

  task automatic apb_write(output logic e);
    @(negedge clk);
    apb.psel = 1'b1;
    apb.pwrite = 1'b1;
    apb.penable = 1'b0;
    @(negedge clk);
    apb.penable = 1'b1;
    #1;
    e = apb.pslverr;
    @(negedge clk);
    apb.psel = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite = 1'b0;
  endtask

  task automatic test_reset();
    apb.psel = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({apb.prdata, apb.pslverr, mem_state,
         apb.pready, overflow} !== {8'h00, 4'b0010}) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=%h",
        {apb.prdata, apb.pslverr, mem_state,
         apb.pready, overflow}, {8'h00, 4'b0010});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] d;
    logic e;
    en_IQ = 1'b1;
    send_byte(8'hA5);
    en_IQ = 1'b0;
    total++;
    if (mem_state !== 1'b1) begin
      bad++;
      $display("FAIL single_mem_state got=%b exp=1", mem_state);
    end
    apb_read(d, e);
    total++;
    if (d !== 8'hA5 || e !== 1'b0) begin
      bad++;
      $display("FAIL single_read got=%h/%b exp=a5/0", d, e);
    end
    total++;
    if (mem_state !== 1'b0) begin
      bad++;
      $display("FAIL single_drained got=%b exp=0", mem_state);
    end
  endtask

  task automatic test_empty_read();
    logic [7:0] d;
    logic e;
    apb_read(d, e);
    total++;
    if (d !== 8'h00 || e !== 1'b1) begin
      bad++;
      $display("FAIL empty_read got=%h/%b exp=00/1", d, e);
    end
    en_IQ = 1'b1;
    send_byte(8'h69);
    en_IQ = 1'b0;
    apb_read(d, e);
    total++;
    if (d !== 8'h69 || e !== 1'b0) begin
      bad++;
      $display("FAIL after_empty got=%h/%b exp=69/0", d, e);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    logic e;
    do_reset();
    en_IQ = 1'b1;
    for (int i = 0; i <= 64; i++) send_byte(8'(i));
    en_IQ = 1'b0;
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set got=%b exp=1", overflow);
    end
    for (int i = 0; i < 64; i++) begin
      apb_read(d, e);
      total++;
      if (d !== 8'(i) || e !== 1'b0) begin
        bad++;
        $display("FAIL ovf_drain[%0d] got=%h/%b exp=%h/0",
          i, d, e, 8'(i));
      end
    end
    apb_read(d, e);
    total++;
    if (d !== 8'h00 || e !== 1'b1) begin
      bad++;
      $display("FAIL ovf_65th got=%h/%b exp=00/1", d, e);
    end
    apb_write(e);
    total++;
    if (e !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear got=%b/%b exp=0/0", e, overflow);
    end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    logic e;
    do_reset();
    en_IQ = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    en_IQ = 1'b0;
    repeat (3) @(negedge clk);
    en_IQ = 1'b1;
    send_byte(8'h3C);
    en_IQ = 1'b0;
    apb_read(d, e);
    total++;
    if (d !== 8'h3C || e !== 1'b0) begin
      bad++;
      $display("FAIL abort_byte got=%h/%b exp=3c/0", d, e);
    end
    apb_read(d, e);
    total++;
    if (e !== 1'b1) begin
      bad++;
      $display("FAIL abort_only_one got=%b exp=1", e);
    end
  endtask

  task automatic test_full_pop_same_cycle();
    logic [7:0] d;
    logic e;
    logic [7:0] c;
    c = 8'hC3;
    do_reset();
    en_IQ = 1'b1;
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    for (int i = 0; i < 7; i++) send_bit(c[i]);
    @(negedge clk);
    data_in = c[7];
    IQ_rate = 1'b1;
    apb.psel = 1'b1;
    apb.pwrite = 1'b0;
    apb.penable = 1'b0;
    @(negedge clk);
    apb.penable = 1'b1;
    #1;
    d = apb.prdata;
    e = apb.pslverr;
    @(negedge clk);
    apb.psel = 1'b0;
    apb.penable = 1'b0;
    IQ_rate = 1'b0;
    repeat (2) @(negedge clk);
    en_IQ = 1'b0;
    total++;
    if (d !== 8'h00 || e !== 1'b0) begin
      bad++;
      $display("FAIL coinc_read got=%h/%b exp=00/0", d, e);
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL coinc_ovf got=%b exp=0", overflow);
    end
    for (int i = 1; i <= 64; i++) begin
      apb_read(d, e);
      total++;
      if (d !== (i == 64 ? c : 8'(i)) || e !== 1'b0) begin
        bad++;
        $display("FAIL coinc_drain[%0d] got=%h/%b exp=%h/0",
          i, d, e, (i == 64 ? c : 8'(i)));
      end
    end
    apb_read(d, e);
    total++;
    if (e !== 1'b1) begin
      bad++;
      $display("FAIL coinc_empty got=%b exp=1", e);
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] d;
    logic e;
    do_reset();
    en_IQ = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    en_IQ = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++;
    if (mem_state !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid got=%b/%b exp=0/0",
        mem_state, overflow);
    end
    apb_read(d, e);
    total++;
    if (e !== 1'b1 || d !== 8'h00) begin
      bad++;
      $display("FAIL rst_mid_read got=%h/%b exp=00/1", d, e);
    end
    en_IQ = 1'b1;
    send_byte(8'h5A);
    en_IQ = 1'b0;
    apb_read(d, e);
    total++;
    if (d !== 8'h5A || e !== 1'b0) begin
      bad++;
      $display("FAIL rst_fresh got=%h/%b exp=5a/0", d, e);
    end
  endtask

  task automatic test_idle_strobes();
    logic [7:0] d;
    logic e;
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    total++;
    if (mem_state !== 1'b0) begin
      bad++;
      $display("FAIL idle_strobe got=%b exp=0", mem_state);
    end
    en_IQ = 1'b1;
    send_byte(8'h81);
    send_byte(8'h7E);
    en_IQ = 1'b0;
    apb_read(d, e);
    total++;
    if (d !== 8'h81 || e !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first got=%h/%b exp=81/0", d, e);
    end
    apb_read(d, e);
    total++;
    if (d !== 8'h7E || e !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second got=%h/%b exp=7e/0", d, e);
    end
  endtask

  initial begin
    apb.psel = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite = 1'b0;
    test_reset();
    test_single();
    test_empty_read();
    test_overflow();
    test_abort();
    test_full_pop_same_cycle();
    test_reset_midstream();
    test_idle_strobes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
